mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter:
// bus widths, state encoding and the default ack timeout.
package mem_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int SELW = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch
// and data access; data wins because it is the older op.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_ce_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic [XLEN-1:0] if_data_o,
  input  logic            mem_ce_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [SELW-1:0] mem_sel_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] mem_data_o,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            sram_req_o,
  output logic            sram_we_o,
  output logic [XLEN-1:0] sram_addr_o,
  output logic [SELW-1:0] sram_sel_o,
  output logic [XLEN-1:0] sram_wdata_o,
  input  logic [XLEN-1:0] sram_rdata_i,
  input  logic            sram_ack_i,
  output logic            bus_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t state, next;

  logic            data_srv;
  logic            inst_srv;
  logic            flushed;
  logic            bus_err;
  logic [XLEN-1:0] data_buf;
  logic [XLEN-1:0] inst_buf;
  logic [CW-1:0]   tcnt;

  logic            busy;
  logic            tmo;
  logic            fin;
  logic            drop;
  logic            keep;
  logic            clr;
  logic            data_pend;
  logic            inst_pend;
  logic            served;
  logic [XLEN-1:0] rdata;

  assign busy      = (state == DATA) || (state == INST);
  assign tmo       = busy && (tcnt == CW'(TIMEOUT - 1));
  assign fin       = busy && (sram_ack_i || tmo);
  assign drop      = flushed || flush_i;
  assign keep      = fin && !drop;
  assign data_pend = mem_ce_i && !data_srv;
  assign inst_pend = if_ce_i && !inst_srv;
  assign served    = data_srv || inst_srv;
  assign rdata     = sram_ack_i ? sram_rdata_i : '0;

  // A flushed transaction still has to drain, but its result is dropped
  assign clr = (state == IDLE && flush_i)
            || (state == DONE)
            || (fin && drop);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (flush_i)        next = IDLE;
        else if (data_pend) next = DATA;
        else if (inst_pend) next = INST;
        else if (served)    next = DONE;
      end
      DATA, INST: if (fin) next = IDLE;
      DONE:       next = IDLE;
      default:    next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_srv <= 1'b0;
      inst_srv <= 1'b0;
      flushed  <= 1'b0;
      bus_err  <= 1'b0;
      data_buf <= '0;
      inst_buf <= '0;
      tcnt     <= '0;
    end else begin
      if (clr) begin
        data_srv <= 1'b0;
        inst_srv <= 1'b0;
        data_buf <= '0;
        inst_buf <= '0;
      end else if (keep && state == DATA) begin
        data_srv <= 1'b1;
        data_buf <= mem_we_i ? '0 : rdata;
      end else if (keep && state == INST) begin
        inst_srv <= 1'b1;
        inst_buf <= rdata;
      end
      flushed <= busy && !fin && drop;
      tcnt    <= (busy && !fin) ? tcnt + CW'(1) : '0;
      if (tmo && !sram_ack_i) bus_err <= 1'b1;
    end
  end

  always_comb begin
    stallreq_o   = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_sel_o   = '0;
    sram_wdata_o = '0;
    if_data_o    = '0;
    mem_data_o   = '0;
    if (!rst) begin
      unique case (state)
        IDLE: stallreq_o = !flush_i && (data_pend || inst_pend || served);
        DATA: begin
          stallreq_o   = 1'b1;
          sram_req_o   = 1'b1;
          sram_we_o    = mem_we_i;
          sram_addr_o  = mem_addr_i;
          sram_sel_o   = mem_sel_i;
          sram_wdata_o = mem_data_i;
        end
        INST: begin
          stallreq_o  = 1'b1;
          sram_req_o  = 1'b1;
          sram_addr_o = if_addr_i;
          sram_sel_o  = '1;
        end
        DONE: begin
          if_data_o  = inst_buf;
          mem_data_o = data_buf;
        end
        default: ;
      endcase
    end
  end

  assign bus_err_o = bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transactions from a
// vector table, then hand-written multi-cycle corner cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        flush_i;
  logic        stallreq_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [31:0] sram_addr_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic        sram_ack_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_ce_i      (if_ce_i),
    .if_addr_i    (if_addr_i),
    .if_data_o    (if_data_o),
    .mem_ce_i     (mem_ce_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_sel_i    (mem_sel_i),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .flush_i      (flush_i),
    .stallreq_o   (stallreq_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_sel_o   (sram_sel_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i),
    .sram_ack_i   (sram_ack_i),
    .bus_err_o    (bus_err_o)
  );

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_mem;
    logic [31:0] exp_if;
    int          exp_stall;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sram_ack_i = 1'b0;
  endtask

  task automatic clear_reqs();
    if_ce_i    = 1'b0;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    flush_i    = 1'b0;
    sram_ack_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int    busy;
    int    stalls;
    bit    done;
    tag    = $sformatf("v%0d", idx);
    busy   = 0;
    stalls = 0;
    done   = 0;
    if (v.is_data) begin
      mem_ce_i   = 1'b1;
      mem_we_i   = v.we;
      mem_addr_i = v.addr;
      mem_sel_i  = v.sel;
      mem_data_i = v.wdata;
    end else begin
      if_ce_i   = 1'b1;
      if_addr_i = v.addr;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (sram_req_o) begin
        busy++;
        chk({tag, "_we"}, 32'(sram_we_o),
            v.is_data ? 32'(v.we) : 32'd0);
        chk({tag, "_addr"}, sram_addr_o, v.addr);
        chk({tag, "_sel"}, 32'(sram_sel_o),
            v.is_data ? 32'(v.sel) : 32'hF);
        chk({tag, "_wdata"}, sram_wdata_o,
            v.is_data ? v.wdata : 32'd0);
        chk({tag, "_busy_out"}, mem_data_o | if_data_o, 32'd0);
        sram_ack_i   = (busy == v.lat);
        sram_rdata_i = sram_ack_i ? v.rdata : 32'hA5A5_A5A5;
      end
      if (stallreq_o) stalls++;
      else begin
        done = 1;
        chk({tag, "_done_req"}, 32'(sram_req_o), 32'd0);
        chk({tag, "_mem_data"}, mem_data_o, v.exp_mem);
        chk({tag, "_if_data"}, if_data_o, v.exp_if);
      end
      tick();
    end
    chk({tag, "_reached_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
    chk({tag, "_busy_cycles"}, 32'(busy), 32'(v.lat));
    clear_reqs();
    @(negedge clk);
    chk({tag, "_after_stall"}, 32'(stallreq_o), 32'd0);
    chk({tag, "_after_data"}, mem_data_o | if_data_o, 32'd0);
    tick();
  endtask

  vec_t vecs[4];

  initial begin
    int dcnt;
    int icnt;
    int done_cyc;
    int first_addr;
    bit done;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 4'hF, 32'h0,
                32'h3C01_0001, 2, 32'h0, 32'h3C01_0001, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h300, 4'b0011, 32'hDEAD_BEEF,
                32'h1234_5678, 1, 32'h0, 32'h0, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 4'hF, 32'h0,
                32'hCAFE_F00D, 3, 32'hCAFE_F00D, 32'h0, 5};
    vecs[3] = '{1'b0, 1'b0, 32'h104, 4'hF, 32'h0,
                32'h0000_0013, 1, 32'h0, 32'h0000_0013, 3};

    rst          = 1'b1;
    if_ce_i      = 1'b1;
    mem_ce_i     = 1'b1;
    mem_we_i     = 1'b1;
    if_addr_i    = 32'h40;
    mem_addr_i   = 32'h80;
    mem_sel_i    = 4'hF;
    mem_data_i   = 32'h1111_1111;
    flush_i      = 1'b0;
    sram_rdata_i = 32'h0;
    sram_ack_i   = 1'b1;

    // reset state: requests present but everything quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_req", 32'(sram_req_o), 32'd0);
    chk("rst_addr", sram_addr_o | sram_wdata_o, 32'd0);
    chk("rst_data", mem_data_o | if_data_o, 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // simultaneous load and fetch
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h200;
    mem_sel_i  = 4'hF;
    if_ce_i    = 1'b1;
    if_addr_i  = 32'h104;
    dcnt = 0; icnt = 0; done = 0;
    done_cyc = -1; first_addr = -1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (sram_req_o) begin
        if (first_addr < 0) first_addr = int'(sram_addr_o);
        if (sram_addr_o == 32'h200) begin
          dcnt++;
          sram_ack_i   = (dcnt == 2);
          sram_rdata_i = 32'h1111_2222;
        end else begin
          icnt++;
          sram_ack_i   = (icnt == 1);
          sram_rdata_i = 32'h3333_4444;
        end
      end
      if (!stallreq_o) begin
        done     = 1;
        done_cyc = c;
        chk("both_mem", mem_data_o, 32'h1111_2222);
        chk("both_if", if_data_o, 32'h3333_4444);
      end
      tick();
    end
    chk("both_first", 32'(first_addr), 32'h200);
    chk("both_done_cyc", 32'(done_cyc), 32'd6);
    chk("both_dcnt", 32'(dcnt), 32'd2);
    chk("both_icnt", 32'(icnt), 32'd1);
    clear_reqs();
    tick();

    // timeout: no ack ever
    mem_ce_i     = 1'b1;
    mem_we_i     = 1'b0;
    mem_addr_i   = 32'h400;
    sram_rdata_i = 32'hFFFF_FFFF;
    dcnt = 0; done = 0; done_cyc = -1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 1) chk("tmo_err_before", 32'(bus_err_o), 32'd0);
      if (sram_req_o) dcnt++;
      if (!stallreq_o) begin
        done     = 1;
        done_cyc = c;
        chk("tmo_mem", mem_data_o, 32'd0);
        chk("tmo_err", 32'(bus_err_o), 32'd1);
      end
      tick();
    end
    chk("tmo_cycles", 32'(dcnt), 32'd4);
    chk("tmo_done_cyc", 32'(done_cyc), 32'd6);
    clear_reqs();
    repeat (2) tick();
    @(negedge clk);
    chk("tmo_sticky", 32'(bus_err_o), 32'd1);
    tick();

    // flush while idle: no stall that cycle, no access issued
    if_ce_i   = 1'b1;
    if_addr_i = 32'h10C;
    flush_i   = 1'b1;
    @(negedge clk);
    chk("fl_idle_stall", 32'(stallreq_o), 32'd0);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("fl_idle_req", 32'(sram_req_o), 32'd0);
    tick();

    // flush during INST, ack one cycle later
    if_ce_i   = 1'b1;
    if_addr_i = 32'h108;
    tick();
    @(negedge clk);
    chk("fl_inst_req", 32'(sram_req_o), 32'd1);
    flush_i = 1'b1;
    tick();
    clear_reqs();
    @(negedge clk);
    chk("fl_inst_hold", 32'(sram_req_o), 32'd1);
    sram_ack_i   = 1'b1;
    sram_rdata_i = 32'h5555_5555;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("fl_stall%0d", c), 32'(stallreq_o), 32'd0);
      chk($sformatf("fl_data%0d", c), if_data_o, 32'd0);
      tick();
    end

    // reset during DATA, ack afterwards is ignored
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h500;
    tick();
    @(negedge clk);
    chk("rd_req_before", 32'(sram_req_o), 32'd1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rd_stall", 32'(stallreq_o), 32'd0);
    chk("rd_req", 32'(sram_req_o), 32'd0);
    chk("rd_err", 32'(bus_err_o), 32'd0);
    tick();
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    chk("rd_idle_req", 32'(sram_req_o), 32'd0);
    sram_ack_i   = 1'b1;
    sram_rdata_i = 32'h0000_0077;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rd_ign_stall%0d", c), 32'(stallreq_o), 32'd0);
      chk($sformatf("rd_ign_data%0d", c), mem_data_o, 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
